mem_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that drives a single-port-write / single-port-read memory.
- The memory has a synchronous write and a combinational read; this block owns its write port and its read address.
- It turns the memory into a valid/ready FIFO with DEPTH = 2**ADDR_WIDTH entries.
- It sits directly upstream of the memory: the producer pushes through this block, and the consumer pops from it.

---
 rtl/mem_fifo_ctrl.sv | 91 +++++++++
 tb/tb_mem_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around an external memory that has
// a synchronous write port and a combinational read port.
//
// Ports:
//   clk_i, arst_ni           clock, asynchronous active-low reset
//   flush_i                  synchronous clear (read pointer jumps to write pointer)
//   in_data_i/valid_i/ready_o    producer push handshake
//   out_data_o/valid_o/ready_i   consumer pop handshake (data straight from memory)
//   count_o, full_o, empty_o, almost_full_o   status from registered pointers
//   mem_we_o, mem_waddr_o, mem_wdata_o        memory write port
//   mem_raddr_o, mem_rdata_i                  memory read port
module mem_fifo_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ALMOST_FULL_TH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;

    logic push;
    logic pop;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        count_o       = wr_ptr_q - rd_ptr_q;
        almost_full_o = (count_o >= AF_TH);
    end

    assign in_ready_o  = !full_o;
    assign out_valid_o = !empty_o;

    // A flush cycle neither writes nor moves pointers on a handshake.
    assign push = in_valid_i & in_ready_o & !flush_i;
    assign pop  = out_valid_o & out_ready_i & !flush_i;

    // Gating with reset keeps the write port idle while reset is held,
    // even if the producer is still presenting data.
    assign mem_we_o    = push & arst_ni;
    assign mem_waddr_o = wr_ptr_q[ADDR_WIDTH-1:0];
    assign mem_wdata_o = in_data_i;
    assign mem_raddr_o = rd_ptr_q[ADDR_WIDTH-1:0];
    assign out_data_o  = mem_rdata_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_mem_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          arst_ni;
    logic          flush_i;
    logic [DW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW:0]   count_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_waddr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [AW-1:0] mem_raddr_o;
    logic [DW-1:0] mem_rdata_i;

    logic [DW-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    int            wa = 0;

    mem_fifo_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ALMOST_FULL_TH(2)
    ) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .flush_i      (flush_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .almost_full_o(almost_full_o),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = mem[mem_raddr_o];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
        forever begin
            @(posedge clk_i);
            if (mem_we_o) mem[mem_waddr_o] = mem_wdata_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of stored entries plus the next write slot.
    initial begin
        forever begin
            @(posedge clk_i or negedge arst_ni);
            if (!arst_ni) begin
                q.delete();
                wa = 0;
            end else if (flush_i) begin
                q.delete();
            end else begin
                bit p;
                bit o;
                p = in_valid_i && (q.size() < DEPTH);
                o = out_ready_i && (q.size() > 0);
                if (o) void'(q.pop_front());
                if (p) begin
                    q.push_back(in_data_i);
                    wa = (wa + 1) % DEPTH;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            begin
                int n;
                bit we;
                n  = q.size();
                we = in_valid_i && (n < DEPTH) && !flush_i && arst_ni;
                chk("m_count", 32'(count_o), 32'(n));
                chk("m_empty", 32'(empty_o), 32'(n == 0));
                chk("m_full", 32'(full_o), 32'(n == DEPTH));
                chk("m_afull", 32'(almost_full_o), 32'(n >= 2));
                chk("m_in_ready", 32'(in_ready_o), 32'(n < DEPTH));
                chk("m_out_valid", 32'(out_valid_o), 32'(n > 0));
                chk("m_we", 32'(mem_we_o), 32'(we));
                chk("m_raddr", 32'(mem_raddr_o), 32'((wa + DEPTH - n) % DEPTH));
                if (we) begin
                    chk("m_waddr", 32'(mem_waddr_o), 32'(wa));
                    chk("m_wdata", 32'(mem_wdata_o), 32'(in_data_i));
                end
                if (n > 0) chk("m_out_data", 32'(out_data_o), 32'(q[0]));
            end
        end
    end

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit           seen_wrap;
        logic [AW-1:0] prev_wa;
        arst_ni     = 1'b0;
        flush_i     = 1'b0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #22;
        arst_ni = 1'b1;
        #2;
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_in_ready", 32'(in_ready_o), 1);
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_we", 32'(mem_we_o), 0);

        // Single push, visible next cycle.
        nxt();
        in_valid_i = 1'b1;
        in_data_i  = 8'hA1;
        @(negedge clk_i);
        chk("a1_we", 32'(mem_we_o), 1);
        chk("a1_waddr", 32'(mem_waddr_o), 0);
        nxt();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("a1_valid", 32'(out_valid_o), 1);
        chk("a1_data", 32'(out_data_o), 32'hA1);
        chk("a1_count", 32'(count_o), 1);
        nxt();
        out_ready_i = 1'b1;
        nxt();
        out_ready_i = 1'b0;

        // Fill to full, then a rejected fifth push.
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(8'h10 + i);
            @(negedge clk_i);
            chk("fill_count", 32'(count_o), 32'(i));
            if (i == 1) chk("fill_af_lo", 32'(almost_full_o), 0);
            if (i == 2) chk("fill_af_hi", 32'(almost_full_o), 1);
            nxt();
        end
        in_data_i = 8'h14;
        @(negedge clk_i);
        chk("full_full", 32'(full_o), 1);
        chk("full_ready", 32'(in_ready_o), 0);
        chk("full_we", 32'(mem_we_o), 0);
        chk("full_count", 32'(count_o), 4);
        nxt();
        in_valid_i = 1'b0;

        // Drain in order.
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("drain_data", 32'(out_data_o), 32'(8'h10 + i));
            nxt();
        end
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("drain_empty", 32'(empty_o), 1);
        nxt();

        // Streaming: push and pop every cycle after the first.
        seen_wrap = 1'b0;
        prev_wa   = '0;
        for (int k = 0; k <= 10; k++) begin
            in_valid_i  = (k < 10);
            in_data_i   = 8'(8'h20 + k);
            out_ready_i = (k > 0);
            @(negedge clk_i);
            if (k > 0) begin
                chk("strm_data", 32'(out_data_o), 32'(8'h20 + k - 1));
                chk("strm_count", 32'(count_o), 1);
            end
            if (mem_we_o) begin
                if (k > 0 && prev_wa == 2'd3 && mem_waddr_o == 2'd0)
                    seen_wrap = 1'b1;
                prev_wa = mem_waddr_o;
            end
            nxt();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("strm_wrap", 32'(seen_wrap), 1);
        @(negedge clk_i);
        chk("strm_empty", 32'(empty_o), 1);
        nxt();

        // Flush with a concurrent push request.
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(8'h30 + i);
            nxt();
        end
        flush_i   = 1'b1;
        in_data_i = 8'h3F;
        @(negedge clk_i);
        chk("fl_we", 32'(mem_we_o), 0);
        chk("fl_ready", 32'(in_ready_o), 1);
        chk("fl_valid", 32'(out_valid_o), 1);
        nxt();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("fl_count", 32'(count_o), 0);
        chk("fl_empty", 32'(empty_o), 1);
        nxt();

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(8'h40 + i);
            nxt();
        end
        in_data_i   = 8'h42;
        out_ready_i = 1'b1;
        #2;
        arst_ni = 1'b0;
        #1;
        chk("ar_count", 32'(count_o), 0);
        chk("ar_empty", 32'(empty_o), 1);
        chk("ar_full", 32'(full_o), 0);
        chk("ar_af", 32'(almost_full_o), 0);
        chk("ar_valid", 32'(out_valid_o), 0);
        chk("ar_ready", 32'(in_ready_o), 1);
        chk("ar_we", 32'(mem_we_o), 0);
        chk("ar_raddr", 32'(mem_raddr_o), 0);
        @(posedge clk_i);
        #3;
        arst_ni     = 1'b1;
        out_ready_i = 1'b0;
        in_data_i   = 8'h55;
        @(negedge clk_i);
        chk("post_we", 32'(mem_we_o), 1);
        chk("post_waddr", 32'(mem_waddr_o), 0);
        nxt();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("post_data", 32'(out_data_o), 32'h55);
        chk("post_count", 32'(count_o), 1);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
